branch_logic: RTL and testbench
===============================

Name: branch_logic

Overview:
- Branch-decision block in the ForthCPU program-counter path.
- Evaluates one condition-code flag selected by the decoded instruction, with optional inversion.
- For a jump instruction it decides taken / not-taken and drives the PC adder controls: offset source PC_OFFSETX and base source PC_BASEX.
- Outputs are registered for one-cycle latency so the PC update path sees stable controls.

Parameters:
none (all encodings are fixed shared constants)

Ports:
CLK  in  1  system clock, rising edge
RESET  in  1  asynchronous active-low reset
CC_ZERO  in  1  Z flag
CC_CARRY  in  1  C flag
CC_PARITY  in  1  P flag
CC_SIGN  in  1  S flag
CC_SELECTX  in  2  flag select: 00 Z, 01 C, 10 S, 11 P
CC_INVERTX  in  1  0 = CC_INVERTX_NONE, 1 = invert selected flag
CC_APPLYX  in  1  0 = CC_APPLYX_NONE (not a conditional jump), 1 = jump conditioned on flag
JMPX  in  2  jump mode: 00 MODE_JMP_ABS_REG, 01 MODE_JMP_REL_HERE, 10 reserved (acts as ABS), 11 reserved (acts as REL)
PC_OFFSETX  out  2  00 PC_OFFSETX_2 (+2), 01 PC_OFFSETX_DIN, 10/11 never driven
PC_BASEX  out  2  00 PC_BASEX_PC_A, 01 PC_BASEX_0, 10/11 never driven

Interface rule (already decided): one clock; reset is asynchronous and active-low; ports are named CLK and RESET.

Behaviour:
- Condition computation (combinational):
  - flag = mux(CC_SELECTX) of Z, C, S, P.
  - cond = flag XOR CC_INVERTX.
  - taken = CC_APPLYX AND cond.
- Next-output computation (combinational):
  - Not taken: offset = PC_OFFSETX_2 (00), base = PC_BASEX_PC_A (00). This is sequential execution, PC + 2.
  - Taken, JMPX[0] = 0 (ABS_REG): offset = PC_OFFSETX_DIN (01), base = PC_BASEX_0 (01). PC = DIN.
  - Taken, JMPX[0] = 1 (REL_HERE): offset = PC_OFFSETX_DIN (01), base = PC_BASEX_PC_A (00). PC = PC_A + DIN.
- When CC_APPLYX = 0, flags, CC_SELECTX, CC_INVERTX and JMPX are ignored; outputs are always 00 / 00.
- Registering:
  - PC_OFFSETX and PC_BASEX are registered on the rising edge of CLK.
  - Latency: inputs stable before edge N produce outputs valid after edge N, held until the next edge.
  - No enable: the outputs update every cycle.
- Reset:
  - RESET low asynchronously forces PC_OFFSETX = 00 and PC_BASEX = 00, i.e. the sequential / not-taken state.
  - Outputs are held at 00 / 00 while RESET is low.
  - The first edge after RESET rises loads normally.
  - Reset asserted mid-branch discards the pending decision.
- Edge cases:
  - Inputs changing between edges have no output effect until the next edge.
  - Inverting with flag = 0 means "branch if not set", so it is taken when CC_APPLYX = 1.
- No X propagation: the reserved JMPX codes follow bit 0 as above; CC_SELECTX decodes fully.

Decomposition:
- Shared constants package/include holds:
  - CC_SELECTX_Z/C/S/P.
  - CC_INVERTX_NONE, CC_APPLYX_NONE.
  - MODE_JMP_ABS_REG, MODE_JMP_REL_HERE.
  - PC_OFFSETX_2, PC_OFFSETX_DIN.
  - PC_BASEX_PC_A, PC_BASEX_0.
- One natural sub-module, cc_eval: a combinational flag mux plus invert plus apply, producing taken.
- The top level adds the JMPX decode and the output registers.

Test Plan:
1. Reset low → 00 / 00 immediately, without a clock edge. Release reset with APPLY = 0 → stays 00 / 00 for several cycles.
2. APPLY = 0, JMPX = ABS_REG, then raise Z, S, P, C one at a time, then set INVERT = 1 → outputs stay PC_OFFSETX_2 / PC_BASEX_PC_A after every edge.
3. APPLY = 1, SELECT = Z, INVERT = 0, JMPX = ABS_REG:
   - Z = 0 → 00 / 00.
   - Z = 1 → after edge, PC_OFFSETX_DIN (01) / PC_BASEX_0 (01).
   - Then INVERT = 1 → back to 00 / 00.
4. JMPX = REL_HERE, APPLY = 1, SELECT = Z:
   - Z = 1, INVERT = 0 → 01 / 00.
   - INVERT = 1 → 00 / 00.
   - Z = 0, INVERT = 1 → 01 / 00.
5. Sweep CC_SELECTX over C, S, P with only the selected flag set and INVERT = 0 → taken; set only a different flag → not taken.
6. Assert RESET mid-sequence while a taken decision is registered → outputs drop to 00 / 00 asynchronously. After release, the next edge reflects the current inputs.

Source files
------------

// File: rtl/branch_logic_pkg.sv
// Shared encodings for the ForthCPU branch path: condition-code selects and PC adder control codes.
package branch_logic_pkg;

  localparam logic [1:0] CC_SELECTX_Z = 2'b00;
  localparam logic [1:0] CC_SELECTX_C = 2'b01;
  localparam logic [1:0] CC_SELECTX_S = 2'b10;
  localparam logic [1:0] CC_SELECTX_P = 2'b11;

  localparam logic CC_INVERTX_NONE = 1'b0;
  localparam logic CC_APPLYX_NONE  = 1'b0;

  localparam logic [1:0] MODE_JMP_ABS_REG  = 2'b00;
  localparam logic [1:0] MODE_JMP_REL_HERE = 2'b01;

  localparam logic [1:0] PC_OFFSETX_2   = 2'b00;
  localparam logic [1:0] PC_OFFSETX_DIN = 2'b01;

  localparam logic [1:0] PC_BASEX_PC_A = 2'b00;
  localparam logic [1:0] PC_BASEX_0    = 2'b01;

  // Reserved jump modes fold onto bit 0: even codes behave as absolute, odd as relative.
  function automatic logic is_rel_jump(input logic [1:0] jmpx);
    return jmpx[0];
  endfunction

endpackage

// File: rtl/branch_logic_cc_eval.sv
// Condition evaluation: select one flag, optionally invert it, and gate with the apply bit.
module branch_logic_cc_eval
  import branch_logic_pkg::*;
(
  input  logic       cc_zero,
  input  logic       cc_carry,
  input  logic       cc_parity,
  input  logic       cc_sign,
  input  logic [1:0] cc_selectx,
  input  logic       cc_invertx,
  input  logic       cc_applyx,
  output logic       taken
);

  logic flag;

  always_comb begin
    flag = cc_zero;
    case (cc_selectx)
      CC_SELECTX_Z: flag = cc_zero;
      CC_SELECTX_C: flag = cc_carry;
      CC_SELECTX_S: flag = cc_sign;
      CC_SELECTX_P: flag = cc_parity;
      default:      flag = cc_zero;
    endcase
  end

  assign taken = (cc_applyx != CC_APPLYX_NONE) && (flag ^ cc_invertx);

endmodule

// File: rtl/branch_logic.sv
// Branch decision for the PC path: decides taken/not-taken and registers the PC adder controls.
module branch_logic
  import branch_logic_pkg::*;
(
  input  logic       CLK,
  input  logic       RESET,
  input  logic       CC_ZERO,
  input  logic       CC_CARRY,
  input  logic       CC_PARITY,
  input  logic       CC_SIGN,
  input  logic [1:0] CC_SELECTX,
  input  logic       CC_INVERTX,
  input  logic       CC_APPLYX,
  input  logic [1:0] JMPX,
  output logic [1:0] PC_OFFSETX,
  output logic [1:0] PC_BASEX
);

  logic       taken;
  logic [1:0] pc_offsetx_reg, pc_offsetx_next;
  logic [1:0] pc_basex_reg, pc_basex_next;

  branch_logic_cc_eval u_cc_eval (
    .cc_zero    (CC_ZERO),
    .cc_carry   (CC_CARRY),
    .cc_parity  (CC_PARITY),
    .cc_sign    (CC_SIGN),
    .cc_selectx (CC_SELECTX),
    .cc_invertx (CC_INVERTX),
    .cc_applyx  (CC_APPLYX),
    .taken      (taken)
  );

  always_comb begin
    pc_offsetx_next = PC_OFFSETX_2;
    pc_basex_next   = PC_BASEX_PC_A;
    if (taken) begin
      pc_offsetx_next = PC_OFFSETX_DIN;
      pc_basex_next   = is_rel_jump(JMPX) ? PC_BASEX_PC_A : PC_BASEX_0;
    end
  end

  // Reset parks the PC adder in sequential (+2) mode, dropping any pending branch.
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      pc_offsetx_reg <= PC_OFFSETX_2;
      pc_basex_reg   <= PC_BASEX_PC_A;
    end else begin
      pc_offsetx_reg <= pc_offsetx_next;
      pc_basex_reg   <= pc_basex_next;
    end
  end

  assign PC_OFFSETX = pc_offsetx_reg;
  assign PC_BASEX   = pc_basex_reg;

endmodule

// File: tb/tb_branch_logic.sv
// Self-checking bench for branch_logic: vector table through a scoreboard, plus reset sequences.
module tb_branch_logic;
  import branch_logic_pkg::*;

  logic       CLK = 1'b0;
  logic       RESET = 1'b1;
  logic       CC_ZERO = 1'b0, CC_CARRY = 1'b0, CC_PARITY = 1'b0, CC_SIGN = 1'b0;
  logic [1:0] CC_SELECTX = 2'b00;
  logic       CC_INVERTX = 1'b0;
  logic       CC_APPLYX = 1'b0;
  logic [1:0] JMPX = 2'b00;
  logic [1:0] PC_OFFSETX, PC_BASEX;

  int n_checks = 0;
  int n_fail = 0;

  typedef struct {
    string      name;
    logic       z, c, s, p;
    logic [1:0] sel;
    logic       inv, app;
    logic [1:0] jmp;
    logic [1:0] exp_off, exp_base;
  } vec_t;

  typedef struct {
    string      name;
    logic [1:0] off, base;
  } exp_t;

  exp_t sb[$];
  vec_t vecs[$];

  branch_logic dut (
    .CLK(CLK), .RESET(RESET),
    .CC_ZERO(CC_ZERO), .CC_CARRY(CC_CARRY), .CC_PARITY(CC_PARITY), .CC_SIGN(CC_SIGN),
    .CC_SELECTX(CC_SELECTX), .CC_INVERTX(CC_INVERTX), .CC_APPLYX(CC_APPLYX),
    .JMPX(JMPX), .PC_OFFSETX(PC_OFFSETX), .PC_BASEX(PC_BASEX)
  );

  always #5 CLK = ~CLK;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish (got timeout, required completion)");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [1:0] off, input logic [1:0] base);
    n_checks++;
    if (PC_OFFSETX !== off || PC_BASEX !== base) begin
      n_fail++;
      $display("FAIL %s: got off=%b base=%b, required off=%b base=%b",
               name, PC_OFFSETX, PC_BASEX, off, base);
    end else begin
      $display("ok   %s: off=%b base=%b", name, PC_OFFSETX, PC_BASEX);
    end
  endtask

  // Drive one vector, queue its expectation, then compare once the edge has registered it.
  task automatic apply(input vec_t v);
    exp_t e;
    CC_ZERO = v.z; CC_CARRY = v.c; CC_SIGN = v.s; CC_PARITY = v.p;
    CC_SELECTX = v.sel; CC_INVERTX = v.inv; CC_APPLYX = v.app; JMPX = v.jmp;
    e.name = v.name; e.off = v.exp_off; e.base = v.exp_base;
    sb.push_back(e);
    @(posedge CLK);
    #1;
    e = sb.pop_front();
    check(e.name, e.off, e.base);
  endtask

  function automatic vec_t mk(input string name, input logic z, input logic c, input logic s,
                              input logic p, input logic [1:0] sel, input logic inv,
                              input logic app, input logic [1:0] jmp,
                              input logic [1:0] off, input logic [1:0] base);
    vec_t v;
    v.name = name; v.z = z; v.c = c; v.s = s; v.p = p; v.sel = sel;
    v.inv = inv; v.app = app; v.jmp = jmp; v.exp_off = off; v.exp_base = base;
    return v;
  endfunction

  initial begin
    // Apply = 0: every flag/invert/jump combination stays sequential.
    vecs.push_back(mk("noapply_idle",  0,0,0,0, 2'b00, 0, 0, 2'b00, 2'b00, 2'b00));
    vecs.push_back(mk("noapply_z",     1,0,0,0, 2'b00, 0, 0, 2'b00, 2'b00, 2'b00));
    vecs.push_back(mk("noapply_s",     0,0,1,0, 2'b10, 0, 0, 2'b00, 2'b00, 2'b00));
    vecs.push_back(mk("noapply_p",     0,0,0,1, 2'b11, 0, 0, 2'b00, 2'b00, 2'b00));
    vecs.push_back(mk("noapply_c",     0,1,0,0, 2'b01, 0, 0, 2'b00, 2'b00, 2'b00));
    vecs.push_back(mk("noapply_inv",   0,0,0,0, 2'b00, 1, 0, 2'b01, 2'b00, 2'b00));
    // Apply = 1, select Z, absolute jump.
    vecs.push_back(mk("abs_z0",        0,0,0,0, 2'b00, 0, 1, 2'b00, 2'b00, 2'b00));
    vecs.push_back(mk("abs_z1",        1,0,0,0, 2'b00, 0, 1, 2'b00, 2'b01, 2'b01));
    vecs.push_back(mk("abs_z1_inv",    1,0,0,0, 2'b00, 1, 1, 2'b00, 2'b00, 2'b00));
    // Relative jump.
    vecs.push_back(mk("rel_z1",        1,0,0,0, 2'b00, 0, 1, 2'b01, 2'b01, 2'b00));
    vecs.push_back(mk("rel_z1_inv",    1,0,0,0, 2'b00, 1, 1, 2'b01, 2'b00, 2'b00));
    vecs.push_back(mk("rel_z0_inv",    0,0,0,0, 2'b00, 1, 1, 2'b01, 2'b01, 2'b00));
    // Flag select sweep, including reserved jump codes.
    vecs.push_back(mk("sel_c_set",     0,1,0,0, 2'b01, 0, 1, 2'b00, 2'b01, 2'b01));
    vecs.push_back(mk("sel_c_other",   1,0,1,1, 2'b01, 0, 1, 2'b00, 2'b00, 2'b00));
    vecs.push_back(mk("sel_s_set",     0,0,1,0, 2'b10, 0, 1, 2'b01, 2'b01, 2'b00));
    vecs.push_back(mk("sel_s_other",   0,0,0,1, 2'b10, 0, 1, 2'b01, 2'b00, 2'b00));
    vecs.push_back(mk("sel_p_set_j2",  0,0,0,1, 2'b11, 0, 1, 2'b10, 2'b01, 2'b01));
    vecs.push_back(mk("sel_p_other",   0,1,0,0, 2'b11, 0, 1, 2'b10, 2'b00, 2'b00));
    vecs.push_back(mk("sel_s_set_j3",  0,0,1,0, 2'b10, 0, 1, 2'b11, 2'b01, 2'b00));
    vecs.push_back(mk("sel_p_inv_j3",  1,1,1,0, 2'b11, 1, 1, 2'b11, 2'b01, 2'b00));

    // Asynchronous reset before any clock edge.
    #2 RESET = 1'b0;
    #1 check("reset_async_initial", 2'b00, 2'b00);
    // Hold reset across edges with a taken input pattern present.
    CC_ZERO = 1'b1; CC_APPLYX = 1'b1; CC_SELECTX = CC_SELECTX_Z; JMPX = MODE_JMP_ABS_REG;
    @(posedge CLK); #1 check("reset_held_taken_inputs", 2'b00, 2'b00);
    CC_ZERO = 1'b0; CC_APPLYX = 1'b0;
    @(negedge CLK) RESET = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(posedge CLK); #1 check($sformatf("post_reset_idle_%0d", i), 2'b00, 2'b00);
    end

    foreach (vecs[i]) apply(vecs[i]);

    // Reset mid-branch: taken decision registered, then asynchronously dropped.
    apply(mk("pre_reset_taken", 1,0,0,0, 2'b00, 0, 1, 2'b00, 2'b01, 2'b01));
    #2 RESET = 1'b0;
    #1 check("reset_mid_branch_async", 2'b00, 2'b00);
    @(posedge CLK); #1 check("reset_mid_branch_held", 2'b00, 2'b00);
    @(negedge CLK) RESET = 1'b1;
    @(posedge CLK); #1 check("first_edge_after_reset", 2'b01, 2'b01);

    // Input change between edges has no effect until the next edge.
    CC_ZERO = 1'b0;
    #2 check("between_edges_hold", 2'b01, 2'b01);
    @(posedge CLK); #1 check("next_edge_updates", 2'b00, 2'b00);

    if (sb.size() != 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL scoreboard_drain: got %0d leftover entries, required 0", sb.size());
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
